// File: rtl/tl_tx_vc_data_buffer_if.sv
// rtl/tl_tx_vc_data_buffer_if.sv - write/read handshake bundle of the TX VC data buffer
// o_r_par_err exists only when TL_TX_DBUF_PARITY_EN is defined.
interface tl_tx_vc_data_buffer_if #(
    parameter int DW              = 32,
    parameter int DATA_FIELD_SIZE = 12,
    parameter int BUFFER_WIDTH    = 8 * DW
);
    logic                       i_w_valid;
    logic [BUFFER_WIDTH-1:0]    i_w_data;
    logic [3:0]                 i_w_dw_cnt;
    logic                       i_w_last;
    logic                       i_w_commit;
    logic                       i_w_discard;
    logic                       o_w_ready;
    logic [DATA_FIELD_SIZE-2:0] o_w_free;
    logic                       i_r_start;
    logic [DATA_FIELD_SIZE-2:0] i_r_len;
    logic                       o_r_busy;
    logic                       o_r_valid;
    logic                       i_r_ready;
    logic [BUFFER_WIDTH-1:0]    o_r_data;
    logic                       o_r_last;
    logic [DATA_FIELD_SIZE-2:0] o_r_used;
`ifdef TL_TX_DBUF_PARITY_EN
    logic                       o_r_par_err;
`endif

    modport slave (
        input  i_w_valid, i_w_data, i_w_dw_cnt, i_w_last, i_w_commit, i_w_discard,
        input  i_r_start, i_r_len, i_r_ready,
        output o_w_ready, o_w_free, o_r_busy, o_r_valid, o_r_data, o_r_last, o_r_used
`ifdef TL_TX_DBUF_PARITY_EN
        , output o_r_par_err
`endif
    );

    modport master (
        output i_w_valid, i_w_data, i_w_dw_cnt, i_w_last, i_w_commit, i_w_discard,
        output i_r_start, i_r_len, i_r_ready,
        input  o_w_ready, o_w_free, o_r_busy, o_r_valid, o_r_data, o_r_last, o_r_used
`ifdef TL_TX_DBUF_PARITY_EN
        , input o_r_par_err
`endif
    );
endinterface

// File: rtl/tl_tx_vc_data_buffer.sv
// rtl/tl_tx_vc_data_buffer.sv - TX per-VC payload buffer: packs DW chunks into 8DW entries, atomic commit/discard, streamed read-out
// Define TL_TX_DBUF_PARITY_EN to store one even-parity bit per DW and flag mismatches on o_r_par_err.
module tl_tx_vc_data_buffer #(
    parameter int DW              = 32,
    parameter int DATA_FIELD_SIZE = 12,
    parameter int BUFFER_WIDTH    = 8 * DW
) (
    input  logic                  i_clk,
    input  logic                  i_n_rst,
    tl_tx_vc_data_buffer_if.slave bus
);
    localparam int ADDR_SIZE = DATA_FIELD_SIZE - 2;
    localparam int DEPTH     = 2 ** ADDR_SIZE;
    localparam int PW        = DATA_FIELD_SIZE - 1;
`ifdef TL_TX_DBUF_PARITY_EN
    localparam int MEM_W     = BUFFER_WIDTH + 8;
`else
    localparam int MEM_W     = BUFFER_WIDTH;
`endif
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [8:0]    DW_9    = 9'(DW);

    typedef enum logic {S_IDLE, S_STREAM} rd_state_e;

    logic [MEM_W-1:0]          mem [DEPTH];

    logic [PW-1:0]             wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, remaining_q;
    logic [BUFFER_WIDTH-1:0]   stage_q, stage_d;
    logic [2:0]                stage_cnt_q, stage_cnt_d;
    rd_state_e                 state_q;
    logic                      r_valid_q, r_last_q;

    logic [PW-1:0]             w_free, r_used;
    logic                      w_ready, w_accept;
    logic [8:0]                stage_sh, beat_sh;
    logic [4:0]                total;
    logic                      full_grp, pad_en, wa_en, wb_en;
    logic [BUFFER_WIDTH-1:0]   beat_data;
    logic [2*BUFFER_WIDTH-1:0] packed_w;
    logic [ADDR_SIZE-1:0]      widx_a, widx_b;
    logic [MEM_W-1:0]          rd_word;
    logic [BUFFER_WIDTH-1:0]   rd_data;

`ifdef TL_TX_DBUF_PARITY_EN
    function automatic logic [7:0] dw_parity(input logic [BUFFER_WIDTH-1:0] d);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) p[7-i] = ^d[BUFFER_WIDTH-1-i*DW -: DW];
        return p;
    endfunction

    function automatic logic [MEM_W-1:0] to_mem(input logic [BUFFER_WIDTH-1:0] d);
        return {d, dw_parity(d)};
    endfunction
`else
    function automatic logic [MEM_W-1:0] to_mem(input logic [BUFFER_WIDTH-1:0] d);
        return d;
    endfunction
`endif

    // packed_w holds stage DWs followed by the new beat's DWs; upper half is the next full entry.
    always_comb begin
        w_free    = DEPTH_P - (wptr_q - rptr_q);
        r_used    = cptr_q - rptr_q;
        w_ready   = i_n_rst && (w_free >= PW'(2)) && !bus.i_w_discard;
        w_accept  = bus.i_w_valid && w_ready;
        stage_sh  = {6'b0, stage_cnt_q} * DW_9;
        beat_sh   = {5'b0, bus.i_w_dw_cnt} * DW_9;
        beat_data = bus.i_w_data & ~({BUFFER_WIDTH{1'b1}} >> beat_sh);
        packed_w  = {stage_q, {BUFFER_WIDTH{1'b0}}}
                  | ({beat_data, {BUFFER_WIDTH{1'b0}}} >> stage_sh);
        total     = {2'b0, stage_cnt_q} + {1'b0, bus.i_w_dw_cnt};
        full_grp  = total >= 5'd8;
        pad_en    = w_accept && bus.i_w_last && (total[2:0] != 3'd0);
        wa_en     = (w_accept && full_grp) || pad_en;
        wb_en     = w_accept && full_grp && pad_en;
        widx_a    = wptr_q[ADDR_SIZE-1:0];
        widx_b    = widx_a + ADDR_SIZE'(1);

        stage_d     = stage_q;
        stage_cnt_d = stage_cnt_q;
        wptr_d      = wptr_q + PW'(wa_en) + PW'(wb_en);
        cptr_d      = bus.i_w_commit ? wptr_d : cptr_q;
        if (bus.i_w_discard) begin
            stage_d     = '0;
            stage_cnt_d = '0;
            wptr_d      = cptr_q;
            cptr_d      = cptr_q;
        end else if (w_accept) begin
            if (bus.i_w_last) begin
                stage_d     = '0;
                stage_cnt_d = '0;
            end else begin
                stage_d     = full_grp ? packed_w[BUFFER_WIDTH-1:0]
                                       : packed_w[2*BUFFER_WIDTH-1:BUFFER_WIDTH];
                stage_cnt_d = total[2:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            wptr_q      <= '0;
            cptr_q      <= '0;
            stage_q     <= '0;
            stage_cnt_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            cptr_q      <= cptr_d;
            stage_q     <= stage_d;
            stage_cnt_q <= stage_cnt_d;
        end
    end

    // Port A always takes the upper half (full entry or lone pad); port B the pad behind a full entry.
    always_ff @(posedge i_clk) begin
        if (wa_en) mem[widx_a] <= to_mem(packed_w[2*BUFFER_WIDTH-1:BUFFER_WIDTH]);
        if (wb_en) mem[widx_b] <= to_mem(packed_w[BUFFER_WIDTH-1:0]);
    end

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            state_q     <= S_IDLE;
            rptr_q      <= '0;
            remaining_q <= '0;
            r_valid_q   <= 1'b0;
            r_last_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_r_start && (bus.i_r_len != '0) && (bus.i_r_len <= r_used)) begin
                        remaining_q <= bus.i_r_len;
                        r_valid_q   <= 1'b1;
                        r_last_q    <= (bus.i_r_len == PW'(1));
                        state_q     <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (bus.i_r_ready) begin
                        rptr_q <= rptr_q + PW'(1);
                        if (remaining_q == PW'(1)) begin
                            remaining_q <= '0;
                            r_valid_q   <= 1'b0;
                            r_last_q    <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            remaining_q <= remaining_q - PW'(1);
                            r_last_q    <= (remaining_q == PW'(2));
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_word = mem[rptr_q[ADDR_SIZE-1:0]];
        rd_data = rd_word[MEM_W-1 -: BUFFER_WIDTH];
    end

    assign bus.o_w_ready = w_ready;
    assign bus.o_w_free  = w_free;
    assign bus.o_r_used  = r_used;
    assign bus.o_r_busy  = (state_q != S_IDLE);
    assign bus.o_r_valid = r_valid_q;
    assign bus.o_r_last  = r_last_q;
    assign bus.o_r_data  = rd_data;
`ifdef TL_TX_DBUF_PARITY_EN
    assign bus.o_r_par_err = r_valid_q && (rd_word[7:0] != dw_parity(rd_data));
`endif
endmodule
